disp_scan: RTL and testbench
============================

Name: disp_scan

Overview:
- Parametrised multi-digit 7-segment display scanner for the next-generation core's display output.
- Replaces the single-digit control/segment byte pair with an N-digit, time-multiplexed display.
- Uses a double-buffered pattern store. Writes go to a back buffer; an explicit swap request is applied at a frame boundary, so partially updated frames are never shown.
- Sits between the syscall/IO write path and the board pins.

Parameters:
- NDIG, 8: number of digits, 1..16. AW = max(1, clog2(NDIG)).
- DIV_W, 16: width of the refresh prescaler and of i_div.
- BLANK, 1: anti-ghosting cycles at the start of each digit slot during which all digits are off.
- ACTIVE_LOW, 1: 1 = o_ctl and o_disp are active-low (inverted); 0 = active-high.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_we  in  1  back-buffer write request
- i_addr  in  AW  digit index for the write
- i_data  in  8  raw pattern (bit0=a .. bit6=g, bit7=dp), or hex value when i_hex=1
- i_hex  in  1  1 = stored pattern is {i_data[7], seg7(i_data[3:0])}
- i_swap  in  1  request back-to-front copy at the next frame end
- i_div  in  DIV_W  digit slot length minus 1, in clocks
- o_ready  out  1  1 = write and swap are accepted this cycle
- o_swap_done  out  1  one-cycle pulse when the swap has been applied
- o_ctl  out  NDIG  one-hot digit enable, polarity per ACTIVE_LOW
- o_disp  out  8  segment pattern of the current digit, polarity per ACTIVE_LOW

Behaviour:
- Reset is asynchronous, active-high, and has the same effect whenever asserted, including mid-frame or with a swap pending. All of the following clear immediately:
  - cnt=0, d=0, pending=0.
  - front[] and back[] all 0 (blank).
  - o_ready=1, o_swap_done=0.
  - o_ctl all inactive: all ones if ACTIVE_LOW, else 0.
  - o_disp inactive: 8'hFF if ACTIVE_LOW, else 8'h00.
- Prescaler:
  - tick = (cnt >= i_div). Using >= makes a mid-slot decrease of i_div safe.
  - On tick: cnt<=0 and d <= (d==NDIG-1) ? 0 : d+1. Otherwise cnt<=cnt+1.
  - i_div=0 gives tick every cycle.
- Frame end = tick while d==NDIG-1.
- Outputs are registered, one cycle after (cnt, d):
  - o_disp = pol(front[d]).
  - o_ctl = pol(onehot(d)) when cnt >= BLANK, otherwise all inactive.
  - If i_div < BLANK, digits are never enabled. This is legal and has no error flag.
- Hex decode, digits 0..F:
  - 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71
  - dp is taken from i_data[7].
- Write: when i_we & o_ready, back[i_addr] <= pattern on the next edge. A write with i_addr >= NDIG is accepted and has no effect.
- Swap handshake:
  - When i_swap & o_ready: pending<=1 and o_ready<=0.
  - At the first frame end strictly after acceptance, in the same edge: front[] <= back[], pending<=0, o_ready<=1, o_swap_done<=1 for exactly one cycle.
  - A frame end in the acceptance cycle itself does not swap.
  - While o_ready=0, i_we and i_swap are ignored and dropped. No queuing.
- Simultaneous i_we and i_swap with o_ready=1: both are accepted, and the swap includes that write.
- back[] is not cleared by a swap, so incremental updates are supported.
- Width rule: cnt is DIV_W bits. d is AW bits and wraps explicitly at NDIG-1, so non-power-of-two NDIG is supported.

Decomposition:
- disp_pkg holds:
  - the 16-entry SEG7 constant table,
  - the segment bit-order constants,
  - a pol() function (XOR with ACTIVE_LOW).
- One sub-module, seg7_dec: combinational nibble-to-7-segment decoder, instantiated on the write path.

Test Plan:
1. Reset, NDIG=4, ACTIVE_LOW=1 -> o_ctl=4'hF, o_disp=8'hFF, o_ready=1, o_swap_done=0. Check that these hold while i_rst=1 regardless of inputs.
2. i_div=3, BLANK=1, no writes -> each digit slot lasts 4 cycles; o_ctl inactive in slot cycle 0 and 4'b1110/1101/1011/0111 in cycles 1-3; scan order 0,1,2,3,0.
3. Write addr 2, i_data=8'h85, i_hex=1, then i_swap -> o_swap_done pulses at frame end. In digit 2 slots afterwards: o_disp=~8'hED=8'h12 and o_ctl=4'b1011.
4. i_swap accepted at d=1 -> o_ready=0 until the frame end, then 1. A write to addr 0 issued while o_ready=0 is absent after the next swap. Same-cycle i_we addr 0 data 8'h01 with i_swap (i_hex=0) -> digit 0 shows 8'hFE after the swap.
5. i_div=0, BLANK=0 -> d advances every cycle and o_ctl rotates one-hot every cycle. i_div=0, BLANK=1 -> o_ctl stays 4'hF permanently.
6. Assert i_rst asynchronously (between clock edges) with pending=1 -> outputs inactive before the next edge, o_ready=1, and after release all digits show blank (8'hFF).

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants for the multi-digit 7-segment scanner: segment bit order,
// the hex-to-segment table and the output polarity helper.
package disp_pkg;

    typedef enum logic [2:0] {
        SEG_A  = 3'd0,
        SEG_B  = 3'd1,
        SEG_C  = 3'd2,
        SEG_D  = 3'd3,
        SEG_E  = 3'd4,
        SEG_F  = 3'd5,
        SEG_G  = 3'd6,
        SEG_DP = 3'd7
    } seg_bit_e;

    // Entry 15 is listed first so SEG7[nibble] selects the matching glyph.
    localparam logic [15:0][6:0] SEG7 = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [15:0] pol(input logic [15:0] v, input logic active_low);
        return v ^ {16{active_low}};
    endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Write/swap port bundle between the IO write path and the display scanner.
interface disp_scan_if #(
    parameter int AW = 3
);
    logic          i_we;
    logic [AW-1:0] i_addr;
    logic [7:0]    i_data;
    logic          i_hex;
    logic          i_swap;
    logic          o_ready;
    logic          o_swap_done;

    modport master (
        output i_we, i_addr, i_data, i_hex, i_swap,
        input  o_ready, o_swap_done
    );

    modport slave (
        input  i_we, i_addr, i_data, i_hex, i_swap,
        output o_ready, o_swap_done
    );
endinterface

// File: rtl/seg7_dec.sv
// Combinational nibble to 7-segment decoder (bit0 = a .. bit6 = g).
module seg7_dec
    import disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = SEG7[i_nib];
endmodule

// File: rtl/disp_scan.sv
// N-digit time-multiplexed 7-segment scanner with a double-buffered pattern
// store; the back buffer is copied to the front only at a frame boundary.
module disp_scan
    import disp_pkg::*;
#(
    parameter int NDIG       = 8,
    parameter int DIV_W      = 16,
    parameter int BLANK      = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    disp_scan_if.slave       bus,
    input  logic [DIV_W-1:0] i_div,
    output logic [NDIG-1:0]  o_ctl,
    output logic [7:0]       o_disp
);
    localparam int                 AW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int                 DP_BIT   = int'(SEG_DP);
    localparam logic [AW-1:0]      D_LAST   = AW'(NDIG - 1);
    localparam logic signed [DIV_W:0] BLANK_S = (DIV_W + 1)'(BLANK);
    localparam logic [NDIG-1:0]    CTL_OFF  = NDIG'(pol(16'h0000, ACTIVE_LOW != 0));
    localparam logic [7:0]         DISP_OFF = 8'(pol(16'h0000, ACTIVE_LOW != 0));

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    d_q, d_d;
    logic             pending_q, pending_d;
    logic             ready_q, ready_d;
    logic             swap_done_q, swap_done_d;
    logic [NDIG-1:0]  ctl_q, ctl_d;
    logic [7:0]       disp_q, disp_d;
    logic [7:0]       front_q [NDIG];
    logic [7:0]       front_d [NDIG];
    logic [7:0]       back_q  [NDIG];
    logic [7:0]       back_d  [NDIG];

    logic       tick, frame_end, we_acc, swap_acc, apply_swap, addr_ok, slot_lit;
    logic [6:0] hex_seg;
    logic [7:0] pattern;
    logic [NDIG-1:0] onehot;

    seg7_dec u_dec (
        .i_nib (bus.i_data[3:0]),
        .o_seg (hex_seg)
    );

    assign bus.o_ready     = ready_q;
    assign bus.o_swap_done = swap_done_q;
    assign o_ctl           = ctl_q;
    assign o_disp          = disp_q;

    always_comb begin
        // >= rather than == keeps the slot bounded if i_div shrinks mid-slot.
        tick       = cnt_q >= i_div;
        frame_end  = tick && (d_q == D_LAST);
        we_acc     = bus.i_we & ready_q;
        swap_acc   = bus.i_swap & ready_q;
        apply_swap = pending_q & frame_end;
        addr_ok    = 32'(bus.i_addr) < NDIG;
        pattern    = bus.i_hex ? {bus.i_data[DP_BIT], hex_seg} : bus.i_data;
        onehot     = NDIG'(1) << d_q;
        slot_lit   = $signed({1'b0, cnt_q}) >= BLANK_S;

        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        d_d   = d_q;
        if (tick) begin
            d_d = (d_q == D_LAST) ? '0 : d_q + AW'(1);
        end

        back_d = back_q;
        if (we_acc && addr_ok) begin
            back_d[bus.i_addr] = pattern;
        end

        front_d     = front_q;
        pending_d   = pending_q;
        ready_d     = ready_q;
        swap_done_d = apply_swap;
        if (apply_swap) begin
            front_d   = back_q;
            pending_d = 1'b0;
            ready_d   = 1'b1;
        end
        if (swap_acc) begin
            pending_d = 1'b1;
            ready_d   = 1'b0;
        end

        disp_d = front_q[d_q] ^ DISP_OFF;
        ctl_d  = slot_lit ? (onehot ^ CTL_OFF) : CTL_OFF;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q       <= '0;
            d_q         <= '0;
            pending_q   <= 1'b0;
            ready_q     <= 1'b1;
            swap_done_q <= 1'b0;
            ctl_q       <= CTL_OFF;
            disp_q      <= DISP_OFF;
            front_q     <= '{default: '0};
            back_q      <= '{default: '0};
        end else begin
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            pending_q   <= pending_d;
            ready_q     <= ready_d;
            swap_done_q <= swap_done_d;
            ctl_q       <= ctl_d;
            disp_q      <= disp_d;
            front_q     <= front_d;
            back_q      <= back_d;
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan (NDIG=4, active-low) with BLANK=1 and BLANK=0 instances
// compared against a cycle-count based reference of the scan and swap rules.
module tb_disp_scan;
    logic        clk;
    logic        rst;
    logic [15:0] div;
    logic [3:0]  ctl1, ctl0;
    logic [7:0]  disp1, disp0;

    int tests = 0;
    int fails = 0;

    disp_scan_if #(.AW(2)) bif1 ();
    disp_scan_if #(.AW(2)) bif0 ();

    assign bif0.i_we   = bif1.i_we;
    assign bif0.i_addr = bif1.i_addr;
    assign bif0.i_data = bif1.i_data;
    assign bif0.i_hex  = bif1.i_hex;
    assign bif0.i_swap = bif1.i_swap;

    disp_scan #(.NDIG(4), .DIV_W(16), .BLANK(1), .ACTIVE_LOW(1)) dut1 (
        .i_clk (clk), .i_rst (rst), .bus (bif1.slave), .i_div (div),
        .o_ctl (ctl1), .o_disp (disp1)
    );

    disp_scan #(.NDIG(4), .DIV_W(16), .BLANK(0), .ACTIVE_LOW(1)) dut0 (
        .i_clk (clk), .i_rst (rst), .bus (bif0.slave), .i_div (div),
        .o_ctl (ctl0), .o_disp (disp0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: position in the scan is derived from edges since reset.
    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [7:0] mf [4];
    logic [7:0] mb [4];
    int         n;
    logic       mpend, mready, mdone;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        n      = 0;
        mpend  = 1'b0;
        mready = 1'b1;
        mdone  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mf[i] = 8'h00;
            mb[i] = 8'h00;
        end
    endtask

    function automatic int cur_d();
        return (n / (int'(div) + 1)) % 4;
    endfunction

    task automatic tick();
        int         p, cp, dp, frame;
        logic       rdy;
        logic [7:0] ed, pat;
        logic [3:0] ec1, ec0;
        @(posedge clk);
        if (rst) begin
            mreset();
            ed  = 8'hFF;
            ec1 = 4'hF;
            ec0 = 4'hF;
        end else begin
            p     = n;
            cp    = p % (int'(div) + 1);
            dp    = (p / (int'(div) + 1)) % 4;
            frame = 4 * (int'(div) + 1);
            ed    = ~mf[dp];
            ec0   = ~(4'b0001 << dp);
            ec1   = (cp >= 1) ? ec0 : 4'hF;
            n++;
            rdy   = mready;
            mdone = 1'b0;
            if (mpend && (n % frame == 0)) begin
                for (int i = 0; i < 4; i++) mf[i] = mb[i];
                mpend  = 1'b0;
                mready = 1'b1;
                mdone  = 1'b1;
            end
            pat = bif1.i_hex ? {bif1.i_data[7], hex_tab[bif1.i_data[3:0]][6:0]} : bif1.i_data;
            if (bif1.i_we && rdy) mb[bif1.i_addr] = pat;
            if (bif1.i_swap && rdy) begin
                mpend  = 1'b1;
                mready = 1'b0;
            end
        end
        #1;
        chk("disp_b1", disp1, ed);
        chk("disp_b0", disp0, ed);
        chk("ctl_b1", ctl1, ec1);
        chk("ctl_b0", ctl0, ec0);
        chk("ready_b1", bif1.o_ready, mready);
        chk("ready_b0", bif0.o_ready, mready);
        chk("swap_done", bif1.o_swap_done, mdone);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_disp"}, disp1, 8'hFF);
        chk({tag, "_ctl"}, ctl1, 4'hF);
        chk({tag, "_ready"}, bif1.o_ready, 1'b1);
        chk({tag, "_done"}, bif1.o_swap_done, 1'b0);
    endtask

    task automatic run_to_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bif1.o_swap_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic idle_inputs();
        bif1.i_we   = 1'b0;
        bif1.i_swap = 1'b0;
        bif1.i_addr = 2'd0;
        bif1.i_data = 8'h00;
        bif1.i_hex  = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        div = 16'd3;
        idle_inputs();
        mreset();
        #1 rst = 1'b1;
        #1 chk_idle("rst_async");

        // Outputs stay inactive under reset whatever the inputs do.
        repeat (3) begin
            bif1.i_we   = 1'b1;
            bif1.i_swap = 1'b1;
            bif1.i_addr = 2'($urandom);
            bif1.i_data = 8'($urandom);
            bif1.i_hex  = 1'($urandom);
            tick();
        end
        idle_inputs();
        rst = 1'b0;

        // Plain scan, div=3.
        repeat (20) tick();

        // Hex write to digit 2 then swap.
        bif1.i_we = 1'b1; bif1.i_addr = 2'd2; bif1.i_data = 8'h85; bif1.i_hex = 1'b1;
        tick();
        idle_inputs();
        bif1.i_swap = 1'b1;
        tick();
        bif1.i_swap = 1'b0;
        run_to_done("swap1_wait");
        repeat (16) tick();

        // Swap accepted at d=1; a write while not ready is dropped.
        for (int i = 0; i < 64 && cur_d() != 1; i++) tick();
        bif1.i_swap = 1'b1;
        tick();
        bif1.i_swap = 1'b0;
        bif1.i_we = 1'b1; bif1.i_addr = 2'd0; bif1.i_data = 8'h3C;
        tick();
        idle_inputs();
        run_to_done("swap2_wait");
        repeat (16) tick();

        // Same-cycle write and swap.
        bif1.i_we = 1'b1; bif1.i_addr = 2'd0; bif1.i_data = 8'h01; bif1.i_swap = 1'b1;
        tick();
        idle_inputs();
        run_to_done("swap3_wait");
        repeat (8) tick();

        // div=0: new digit every cycle.
        rst = 1'b1; div = 16'd0;
        tick();
        rst = 1'b0;
        repeat (12) tick();

        // Asynchronous reset with a swap pending.
        rst = 1'b1; div = 16'd2;
        tick();
        rst = 1'b0;
        bif1.i_we = 1'b1; bif1.i_addr = 2'd1; bif1.i_data = 8'h07; bif1.i_hex = 1'b1;
        bif1.i_swap = 1'b1;
        tick();
        idle_inputs();
        tick();
        #3 rst = 1'b1;
        #1 chk_idle("rst_mid");
        mreset();
        tick();
        rst = 1'b0;
        repeat (16) tick();

        // Randomised traffic over several prescaler settings.
        for (int r = 0; r < 6; r++) begin
            rst = 1'b1;
            div = 16'($urandom_range(0, 4));
            idle_inputs();
            tick();
            rst = 1'b0;
            repeat (60) begin
                bif1.i_we   = ($urandom_range(0, 3) == 0);
                bif1.i_swap = ($urandom_range(0, 7) == 0);
                bif1.i_addr = 2'($urandom);
                bif1.i_data = 8'($urandom);
                bif1.i_hex  = 1'($urandom);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
